// File: rtl/multi_event_cntr_regs.sv
// Multi-channel event counters (wrap/saturate, reset-on-read, lo/hi snapshot) on the UDP register ring.
// Ring latency is one cycle, and ring requests are never stalled.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module multi_event_cntr_regs #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int NUM_CNTRS         = 8,
  parameter int INPUT_WIDTH       = 1,
  parameter int CNTR_WIDTH        = 48,
  parameter int SATURATE          = 0,
  parameter int RESET_ON_READ     = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              reg_req_in,
  input  logic                              reg_ack_in,
  input  logic                              reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in,
  output logic                              reg_req_out,
  output logic                              reg_ack_out,
  output logic                              reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,
  input  logic [NUM_CNTRS*INPUT_WIDTH-1:0]  updates
);

  localparam int TAG_W = `UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam logic [TAG_W-1:0]          TAG_V    = TAG_W'(TAG);
  localparam logic [REG_ADDR_WIDTH-1:0] CTRL_A   = REG_ADDR_WIDTH'(2 * NUM_CNTRS);
  localparam logic [31:0]               BAD_DATA = 32'hDEADBEEF;

  logic [CNTR_WIDTH-1:0] cntr_q [NUM_CNTRS];
  logic [CNTR_WIDTH-1:0] cntr_d [NUM_CNTRS];
  logic [31:0]           shadow_q, shadow_d;
  logic                  freeze_q, freeze_d;

  logic                            req_q, req_d;
  logic                            ack_q, ack_d;
  logic                            rw_q, rw_d;
  logic [`UDP_REG_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [`CPCI_NF2_DATA_WIDTH-1:0] data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0]    src_q, src_d;

  logic                      claim, rd, wr, is_cntr, is_ctrl, is_hi, clear_all, hit;
  logic [REG_ADDR_WIDTH-1:0] addr;
  logic [REG_ADDR_WIDTH-2:0] idx;
  logic [63:0]               sel64, cur64;
  logic [CNTR_WIDTH:0]       sum, upd_ext;
  logic [CNTR_WIDTH-1:0]     inc_val;
  logic [31:0]               rd_data;

  always_comb begin
    addr      = reg_addr_in[REG_ADDR_WIDTH-1:0];
    idx       = addr[REG_ADDR_WIDTH-1:1];
    is_hi     = addr[0];
    claim     = reg_req_in && !reg_ack_in &&
                (reg_addr_in[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == TAG_V);
    rd        = claim && reg_rd_wr_L_in;
    wr        = claim && !reg_rd_wr_L_in;
    is_cntr   = addr < CTRL_A;
    is_ctrl   = addr == CTRL_A;
    clear_all = wr && is_ctrl && reg_data_in[1];

    sel64 = '0;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      if (int'(idx) == i) sel64 = 64'(cntr_q[i]);
    end

    sum     = '0;
    upd_ext = '0;
    inc_val = '0;
    hit     = 1'b0;
    cur64   = '0;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      // One extra bit of headroom: counter max plus an 8-bit increment always fits.
      upd_ext = (CNTR_WIDTH+1)'(updates[i*INPUT_WIDTH +: INPUT_WIDTH]);
      sum     = {1'b0, cntr_q[i]} + upd_ext;
      if (SATURATE != 0 && sum[CNTR_WIDTH]) inc_val = '1;
      else                                  inc_val = sum[CNTR_WIDTH-1:0];
      if (freeze_q) inc_val = cntr_q[i];

      hit   = is_cntr && (int'(idx) == i);
      cur64 = 64'(cntr_q[i]);

      cntr_d[i] = inc_val;
      if (clear_all) begin
        cntr_d[i] = '0;
      end else if (hit && wr) begin
        if (is_hi) cntr_d[i] = CNTR_WIDTH'({reg_data_in[31:0], cur64[31:0]});
        else       cntr_d[i] = CNTR_WIDTH'({cur64[63:32], reg_data_in[31:0]});
      end else if (hit && rd && !is_hi && RESET_ON_READ != 0) begin
        cntr_d[i] = freeze_q ? '0 : upd_ext[CNTR_WIDTH-1:0];
      end
    end

    shadow_d = shadow_q;
    if (clear_all)                   shadow_d = '0;
    else if (rd && is_cntr && !is_hi) shadow_d = sel64[63:32];

    freeze_d = (wr && is_ctrl) ? reg_data_in[0] : freeze_q;

    if (is_cntr)      rd_data = is_hi ? shadow_q : sel64[31:0];
    else if (is_ctrl) rd_data = {31'd0, freeze_q};
    else              rd_data = BAD_DATA;

    req_d  = reg_req_in;
    rw_d   = reg_rd_wr_L_in;
    addr_d = reg_addr_in;
    src_d  = reg_src_in;
    ack_d  = claim ? 1'b1 : reg_ack_in;
    data_d = rd ? `CPCI_NF2_DATA_WIDTH'(rd_data) : reg_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q    <= 1'b0;
      ack_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      src_q    <= '0;
      shadow_q <= '0;
      freeze_q <= 1'b0;
      for (int i = 0; i < NUM_CNTRS; i++) cntr_q[i] <= '0;
    end else begin
      req_q    <= req_d;
      ack_q    <= ack_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      src_q    <= src_d;
      shadow_q <= shadow_d;
      freeze_q <= freeze_d;
      for (int i = 0; i < NUM_CNTRS; i++) cntr_q[i] <= cntr_d[i];
    end
  end

  assign reg_req_out     = req_q;
  assign reg_ack_out     = ack_q;
  assign reg_rd_wr_L_out = rw_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;

endmodule

// File: tb/tb_multi_event_cntr_regs.sv
// Bench: three counter blocks (default, saturating 8-bit, wrapping reset-on-read 8-bit) on shared ring inputs.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_multi_event_cntr_regs;
  localparam int AW = `UDP_REG_ADDR_WIDTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [31:0]   reg_data_in;
  logic [1:0]    reg_src_in;
  logic [7:0]    upd_a;
  logic [15:0]   upd_b, upd_c;

  logic          req_o [3];
  logic          ack_o [3];
  logic          rw_o  [3];
  logic [AW-1:0] addr_o[3];
  logic [31:0]   data_o[3];
  logic [1:0]    src_o [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_event_cntr_regs #(.TAG(0)) u_a (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(req_o[0]), .reg_ack_out(ack_o[0]), .reg_rd_wr_L_out(rw_o[0]),
    .reg_addr_out(addr_o[0]), .reg_data_out(data_o[0]), .reg_src_out(src_o[0]),
    .updates(upd_a));

  multi_event_cntr_regs #(.TAG(1), .NUM_CNTRS(4), .INPUT_WIDTH(4), .CNTR_WIDTH(8),
                          .SATURATE(1), .RESET_ON_READ(0)) u_b (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(req_o[1]), .reg_ack_out(ack_o[1]), .reg_rd_wr_L_out(rw_o[1]),
    .reg_addr_out(addr_o[1]), .reg_data_out(data_o[1]), .reg_src_out(src_o[1]),
    .updates(upd_b));

  multi_event_cntr_regs #(.TAG(2), .NUM_CNTRS(4), .INPUT_WIDTH(4), .CNTR_WIDTH(8),
                          .SATURATE(0), .RESET_ON_READ(1)) u_c (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(req_o[2]), .reg_ack_out(ack_o[2]), .reg_rd_wr_L_out(rw_o[2]),
    .reg_addr_out(addr_o[2]), .reg_data_out(data_o[2]), .reg_src_out(src_o[2]),
    .updates(upd_c));

  typedef struct {
    int          chk;
    int          tag;
    logic        req;
    logic        ack_in;
    logic [4:0]  addr;
    logic        rd;
    logic [31:0] wdata;
    logic [7:0]  ua;
    logic [15:0] ub;
    logic [15:0] uc;
    logic        exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t raw(int chk, int tag, logic req, logic ack_in, logic [4:0] addr,
                               logic rd, logic [31:0] wdata, logic [7:0] ua, logic [15:0] ub,
                               logic [15:0] uc, logic exp_ack, logic [31:0] exp_data);
    vec_t v;
    v.chk = chk; v.tag = tag; v.req = req; v.ack_in = ack_in; v.addr = addr; v.rd = rd;
    v.wdata = wdata; v.ua = ua; v.ub = ub; v.uc = uc; v.exp_ack = exp_ack; v.exp_data = exp_data;
    return v;
  endfunction

  function automatic vec_t rdv(int chk, int tag, logic [4:0] addr, logic [7:0] ua,
                               logic [15:0] ub, logic [15:0] uc, logic [31:0] exp_data);
    return raw(chk, tag, 1'b1, 1'b0, addr, 1'b1, 32'h0, ua, ub, uc, 1'b1, exp_data);
  endfunction

  // Claimed writes pass the write data through on the ring.
  function automatic vec_t wrv(int chk, int tag, logic [4:0] addr, logic [31:0] wdata,
                               logic [7:0] ua, logic [15:0] ub, logic [15:0] uc);
    return raw(chk, tag, 1'b1, 1'b0, addr, 1'b0, wdata, ua, ub, uc, 1'b1, wdata);
  endfunction

  function automatic vec_t idle(int chk, logic [7:0] ua, logic [15:0] ub, logic [15:0] uc);
    return raw(chk, 0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0, ua, ub, uc, 1'b0, 32'h0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input int tag, input logic req, input logic ack_in, input logic [4:0] addr,
                       input logic rd, input logic [31:0] wdata);
    reg_req_in     = req;
    reg_ack_in     = ack_in;
    reg_rd_wr_L_in = rd;
    reg_addr_in    = AW'((tag << 5) | int'(addr));
    reg_data_in    = wdata;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.tag, v.req, v.ack_in, v.addr, v.rd, v.wdata);
    upd_a = v.ua; upd_b = v.ub; upd_c = v.uc;
    @(posedge clk); #1;
    check($sformatf("v%0d_ack", idx), 32'(ack_o[v.chk]), 32'(v.exp_ack));
    check($sformatf("v%0d_data", idx), data_o[v.chk], v.exp_data);
  endtask

  initial begin
    reg_src_in = 2'b10;
    upd_a = '0; upd_b = '0; upd_c = '0;

    // Counter 3 pulse count, then lo/hi read.
    for (int k = 0; k < 5; k++) vq.push_back(idle(0, 8'h08, 16'h0, 16'h0));
    vq.push_back(rdv(0, 0, 5'd6, 8'h00, 16'h0, 16'h0, 32'd5));
    vq.push_back(rdv(0, 0, 5'd7, 8'h00, 16'h0, 16'h0, 32'd0));
    // 48-bit carry across the word boundary and the shared hi snapshot.
    vq.push_back(wrv(0, 0, 5'd1, 32'h00000FFF, 8'h00, 16'h0, 16'h0));
    vq.push_back(wrv(0, 0, 5'd0, 32'hFFFFFFFE, 8'h00, 16'h0, 16'h0));
    for (int k = 0; k < 3; k++) vq.push_back(idle(0, 8'h01, 16'h0, 16'h0));
    vq.push_back(rdv(0, 0, 5'd0, 8'h01, 16'h0, 16'h0, 32'h00000001));
    vq.push_back(idle(0, 8'h01, 16'h0, 16'h0));
    vq.push_back(rdv(0, 0, 5'd1, 8'h01, 16'h0, 16'h0, 32'h00001000));
    vq.push_back(rdv(0, 0, 5'd3, 8'h00, 16'h0, 16'h0, 32'h00001000));
    // Freeze, writes while frozen, then clear_all.
    vq.push_back(wrv(0, 0, 5'd16, 32'h1, 8'h00, 16'h0, 16'h0));
    for (int k = 0; k < 4; k++) vq.push_back(idle(0, 8'hFF, 16'h0, 16'h0));
    vq.push_back(rdv(0, 0, 5'd6, 8'h00, 16'h0, 16'h0, 32'd5));
    vq.push_back(rdv(0, 0, 5'd16, 8'h00, 16'h0, 16'h0, 32'h1));
    vq.push_back(wrv(0, 0, 5'd12, 32'h77, 8'hFF, 16'h0, 16'h0));
    vq.push_back(rdv(0, 0, 5'd12, 8'hFF, 16'h0, 16'h0, 32'h77));
    vq.push_back(wrv(0, 0, 5'd16, 32'h2, 8'hFF, 16'h0, 16'h0));
    vq.push_back(rdv(0, 0, 5'd16, 8'h00, 16'h0, 16'h0, 32'h0));
    vq.push_back(rdv(0, 0, 5'd1, 8'h00, 16'h0, 16'h0, 32'h0));
    vq.push_back(rdv(0, 0, 5'd6, 8'h00, 16'h0, 16'h0, 32'h0));
    vq.push_back(idle(0, 8'h08, 16'h0, 16'h0));
    vq.push_back(rdv(0, 0, 5'd6, 8'h00, 16'h0, 16'h0, 32'd1));
    // Out-of-range address, foreign tag, already-acked request.
    vq.push_back(rdv(0, 0, 5'd17, 8'h00, 16'h0, 16'h0, 32'hDEADBEEF));
    vq.push_back(wrv(0, 0, 5'd17, 32'h5A5A0000, 8'h00, 16'h0, 16'h0));
    vq.push_back(raw(0, 5, 1'b1, 1'b0, 5'd6, 1'b1, 32'h12345678, 8'h00, 16'h0, 16'h0, 1'b0, 32'h12345678));
    vq.push_back(raw(0, 0, 1'b1, 1'b1, 5'd6, 1'b1, 32'hA5A5A5A5, 8'h00, 16'h0, 16'h0, 1'b1, 32'hA5A5A5A5));
    // Saturating 8-bit block: 0xFE + 0xF clamps and stays at 0xFF.
    vq.push_back(wrv(1, 1, 5'd0, 32'hFE, 8'h00, 16'h0, 16'h0));
    vq.push_back(idle(1, 8'h00, 16'h000F, 16'h0));
    vq.push_back(rdv(1, 1, 5'd0, 8'h00, 16'h0, 16'h0, 32'hFF));
    vq.push_back(idle(1, 8'h00, 16'h000F, 16'h0));
    vq.push_back(rdv(1, 1, 5'd0, 8'h00, 16'h0, 16'h0, 32'hFF));
    vq.push_back(rdv(1, 1, 5'd1, 8'h00, 16'h0, 16'h0, 32'h0));
    // Wrapping reset-on-read block: 0xFE + 0xF wraps to 0x0D; increment survives a clearing read.
    vq.push_back(wrv(2, 2, 5'd0, 32'hFE, 8'h00, 16'h0, 16'h0));
    vq.push_back(idle(2, 8'h00, 16'h0, 16'h000F));
    vq.push_back(rdv(2, 2, 5'd0, 8'h00, 16'h0, 16'h0, 32'h0D));
    vq.push_back(wrv(2, 2, 5'd4, 32'd10, 8'h00, 16'h0, 16'h0));
    vq.push_back(rdv(2, 2, 5'd4, 8'h00, 16'h0, 16'h0100, 32'd10));
    vq.push_back(rdv(2, 2, 5'd4, 8'h00, 16'h0, 16'h0, 32'd1));
    vq.push_back(rdv(2, 2, 5'd0, 8'h00, 16'h0, 16'h0, 32'h0));

    // Reset with a live request on the inputs: every output must be zero.
    drive(0, 1'b1, 1'b0, 5'd6, 1'b1, 32'hFFFFFFFF);
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ack%0d", k), 32'(ack_o[k]), 32'h0);
      check($sformatf("rst_data%0d", k), data_o[k], 32'h0);
      check($sformatf("rst_req%0d", k), 32'(req_o[k]), 32'h0);
    end
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Unclaimed request: every ring field is forwarded.
    drive(5, 1'b1, 1'b0, 5'd3, 1'b0, 32'hCAFEF00D);
    upd_a = '0; upd_b = '0; upd_c = '0;
    @(posedge clk); #1;
    check("pt_req", 32'(req_o[0]), 32'h1);
    check("pt_rw", 32'(rw_o[0]), 32'h0);
    check("pt_addr", 32'(addr_o[0]), 32'((5 << 5) | 3));
    check("pt_src", 32'(src_o[2]), 32'h2);
    check("pt_data", data_o[1], 32'hCAFEF00D);

    // Reset during a claimed read discards it and zeroes counter 3 (currently 1).
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 5'd6, 1'b1, 32'h0);
    @(posedge clk); #1;
    check("midrst_ack", 32'(ack_o[0]), 32'h0);
    check("midrst_data", data_o[0], 32'h0);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 5'd6, 1'b1, 32'h0);
    @(posedge clk); #1;
    check("postrst_ack", 32'(ack_o[0]), 32'h1);
    check("postrst_c3", data_o[0], 32'h0);
    drive(0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
